mtr_drv: RTL



---
 rtl/mtr_pkg.sv | 20 ++
 rtl/mtr_drv_nonoverlap.sv | 47 ++++
 rtl/mtr_drv.sv | 94 +++++++++
 3 files changed

// File: rtl/mtr_pkg.sv
// Shared motor-drive types: coil select encoding and PWM constants.
// Imported by mtr_drv and by the commutation block.
package mtr_pkg;

    typedef enum logic [1:0] {
        HIGH_Z   = 2'b00,
        LOW_PWM  = 2'b01,
        HIGH_PWM = 2'b10,
        BRAKE    = 2'b11
    } sel_t;

    localparam int          PWM_PERIOD = 2048;
    localparam logic [10:0] BRAKE_DUTY = 11'h600;

    typedef struct packed {
        logic hi;
        logic lo;
    } drive_t;

endpackage

// File: rtl/mtr_drv_nonoverlap.sv
// Per-phase non-overlap stage: blanks both gates for DEAD clocks on any
// change of the requested drive, and never drives high and low together.
module nonoverlap #(
    parameter int DEAD = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic highIn,
    input  logic lowIn,
    output logic highOut,
    output logic lowOut
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD - 1);

    logic [7:0] dead_cnt;
    logic       hi_prev;
    logic       lo_prev;
    logic       changed;

    assign changed = (highIn != hi_prev) || (lowIn != lo_prev);

    // Counter saturates at DEAD_LAST; outputs follow the request from then on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_prev  <= 1'b0;
            lo_prev  <= 1'b0;
            dead_cnt <= '0;
            highOut  <= 1'b0;
            lowOut   <= 1'b0;
        end else begin
            hi_prev <= highIn;
            lo_prev <= lowIn;
            if (changed || (highIn && lowIn)) begin
                highOut  <= 1'b0;
                lowOut   <= 1'b0;
                dead_cnt <= '0;
            end else if (dead_cnt == DEAD_LAST) begin
                highOut <= highIn;
                lowOut  <= lowIn;
            end else begin
                dead_cnt <= dead_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Three-phase FET bridge driver: 2048-clock PWM, select-to-gate mapping and
// dead-time insertion. Optional duty ceiling enabled by DUTY_CLAMP_EN.
module mtr_drv
    import mtr_pkg::*;
#(
    parameter int          DEAD     = 32,
    parameter logic [10:0] MAX_DUTY = 11'h7C0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] duty,
    input  logic [1:0]  selGrn,
    input  logic [1:0]  selYlw,
    input  logic [1:0]  selBlu,
    output logic        highGrn,
    output logic        lowGrn,
    output logic        highYlw,
    output logic        lowYlw,
    output logic        highBlu,
    output logic        lowBlu,
    output logic        PWM_synch
);

    localparam logic [10:0] CNT_LAST = 11'(PWM_PERIOD - 1);

    logic [10:0] cnt;
    logic [10:0] duty_lat;
    logic [10:0] duty_next;
    logic        PWM_sig;
    drive_t      grn_d, ylw_d, blu_d;

`ifdef DUTY_CLAMP_EN
    always_comb begin
        duty_next = duty;
        if (duty > MAX_DUTY) duty_next = MAX_DUTY;
    end
`else
    logic unused_max_duty;
    assign unused_max_duty = ^MAX_DUTY;

    always_comb begin
        duty_next = duty;
    end
`endif

    // Duty is latched at the period boundary so mid-period writes never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            duty_lat  <= '0;
            PWM_sig   <= 1'b0;
            PWM_synch <= 1'b0;
        end else begin
            cnt       <= cnt + 11'd1;
            PWM_sig   <= (cnt < duty_lat);
            PWM_synch <= (cnt == CNT_LAST);
            if (cnt == CNT_LAST) duty_lat <= duty_next;
        end
    end

    function automatic drive_t sel_drive(input sel_t sel, input logic pwm);
        drive_t d;
        d = '0;
        case (sel)
            LOW_PWM:  begin d.hi = ~pwm; d.lo = pwm;  end
            HIGH_PWM: begin d.hi = pwm;  d.lo = ~pwm; end
            BRAKE:    begin d.hi = 1'b0; d.lo = pwm;  end
            default:  d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        grn_d = sel_drive(sel_t'(selGrn), PWM_sig);
        ylw_d = sel_drive(sel_t'(selYlw), PWM_sig);
        blu_d = sel_drive(sel_t'(selBlu), PWM_sig);
    end

    nonoverlap #(.DEAD(DEAD)) u_grn (
        .clk(clk), .rst(rst), .highIn(grn_d.hi), .lowIn(grn_d.lo),
        .highOut(highGrn), .lowOut(lowGrn)
    );

    nonoverlap #(.DEAD(DEAD)) u_ylw (
        .clk(clk), .rst(rst), .highIn(ylw_d.hi), .lowIn(ylw_d.lo),
        .highOut(highYlw), .lowOut(lowYlw)
    );

    nonoverlap #(.DEAD(DEAD)) u_blu (
        .clk(clk), .rst(rst), .highIn(blu_d.hi), .lowIn(blu_d.lo),
        .highOut(highBlu), .lowOut(lowBlu)
    );

endmodule
